if_fetch_ctrl: RTL and testbench
================================

// Module: if_fetch_ctrl
// PURPOSE
//  Instruction-fetch controller in the IF stage. Owns the fetch PC and sequences a 1-cycle-latency
//  synchronous instruction ROM. Buffers returned words in a 2-entry queue so decode stalls never
//  lose an instruction. Applies branch/jump redirects with flush, and flags illegal fetch addresses.
// PARAMETERS
//  RESET_PC  32'h0000_3000  fetch PC after reset
//  IM_BASE   32'h0000_3000  byte address of ROM word 0
//  IM_DEPTH  4096           ROM depth in words
//  ADDR_W    12             ROM word-index width; must equal clog2(IM_DEPTH)
// PORTS
//  clk          in   1       clock; all state updates on the rising edge
//  reset        in   1       asynchronous, active-high reset
//  im_en        out  1       ROM read strobe
//  im_addr      out  ADDR_W  ROM word index = (fpc - IM_BASE) >> 2
//  im_rdata     in   32      ROM data; valid the cycle after an im_en cycle
//  stall        in   1       decode not ready; head entry is held
//  redirect     in   1       taken branch/jump: flush and refetch
//  redirect_pc  in   32      redirect target byte address
//  instr_valid  out  1       instr/instr_pc hold a valid fetched word
//  instr        out  32      head instruction word (0 when !instr_valid)
//  instr_pc     out  32      byte address of instr (0 when !instr_valid)
//  pc_fault     out  1       fetch halted on a misaligned or out-of-range PC
// BEHAVIOUR
//  Reset (async): fpc=RESET_PC; queue empty; inflight=0; state=RUN.
//   All outputs 0 except im_addr=(RESET_PC-IM_BASE)>>2.
//  Legal PC: fpc[1:0]==0 and IM_BASE <= fpc < IM_BASE+4*IM_DEPTH. Use 33-bit compare; no wrap.
//  pop  = instr_valid & ~stall.
//  Issue, combinational: im_en = state==RUN & legal(fpc) & ~redirect
//   & (count+inflight < 2 | pop).
//  On an issue edge: inflight<=1 and tag<=fpc; fpc<=fpc+4.
//  Otherwise inflight<=0 and fpc holds.
//  Return: if inflight & ~redirect, push {im_rdata, tag} at the edge; the push is never blocked.
//  Latency: first im_en is cycle 0 after reset release; instr_valid rises in cycle 2
//   with instr_pc=RESET_PC.
//  Throughput: 1 instr/cycle while ~stall. Outstanding words (count+inflight) never exceed 2.
//  Queue: 2 entries, FIFO order. Head drives instr/instr_pc directly, no output register.
//   A push and a pop in the same edge are both honoured.
//  Redirect (priority over everything):
//   - at the edge: queue cleared, in-flight response discarded, fpc<=redirect_pc, state<=RUN;
//   - the same cycle: im_en=0; next cycle issues from redirect_pc if legal;
//   - redirect during stall: stall is ignored for the flushed entries.
//  FSM:
//   RUN   -> FAULT when fpc is illegal, queue is empty and inflight=0.
//            Older legal words drain first.
//   FAULT -> pc_fault=1, im_en=0, instr_valid=0. Left only by redirect (to RUN) or reset.
//  fpc at the last legal word (IM_BASE+4*IM_DEPTH-4): the word issues normally.
//   The next fpc is illegal and leads to FAULT.
//  Reset mid-operation: queue and inflight discarded; the late im_rdata is ignored.
// STRUCTURE
//  Shared package mips_pkg: IM_BASE, RESET_PC, INSTR_W=32, fetch-state enum {FS_RUN, FS_FAULT}.
//  One sub-module: fetch_q2. 2-entry FIFO of {instr[31:0], pc[31:0]} with push, pop, flush,
//   count[1:0] and head outputs, async reset to empty.
//  Top level holds fpc, inflight/tag, FSM and issue logic.
// TESTING
//  1. Reset release, stall=0, ROM[i]=32'h1000_0000+i
//     -> im_addr 0,1,2,... on consecutive cycles.
//     -> cycle 2: instr_pc=0x3000, instr=0x1000_0000; then +4/+1 every cycle, no bubbles.
//  2. stall=1 for 4 cycles once instr_pc=0x3008
//     -> instr holds 0x3008's word; im_en drops after 2 outstanding.
//     -> after release 0x3008, 0x300C, 0x3010 in order, none lost or duplicated.
//  3. redirect=1, redirect_pc=0x3040 while a word is in flight and the queue is full
//     -> next instr_valid shows instr_pc=0x3040, two cycles later; no stale 0x30xx word appears.
//  4. redirect with stall=1 in the same cycle
//     -> queue flushed; then 0x3040 is held until stall falls.
//  5. redirect_pc=0x3002
//     -> im_en stays 0; pc_fault=1 next cycle.
//     -> a later redirect_pc=0x3000 clears pc_fault and fetch resumes.
//  6. redirect_pc=0x6FF8
//     -> words 0x6FF8 and 0x6FFC delivered, then pc_fault=1.
//     -> reset asserted mid-stream: all outputs 0 at once; restart at 0x3000.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared IF-stage definitions: instruction-memory map, fetch FSM states and the
// fetch-queue entry layout.
package mips_pkg;

  localparam int          INSTR_W   = 32;
  localparam logic [31:0] IM_BASE   = 32'h0000_3000;
  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam int          IM_DEPTH  = 4096;
  localparam int          IM_ADDR_W = 12;

  typedef enum logic {
    FS_RUN   = 1'b0,
    FS_FAULT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fetch_entry_t;

  // 33-bit compare so a window ending at 2^32 cannot wrap.
  function automatic logic pc_legal(input logic [31:0] pc, input logic [31:0] base,
                                    input int depth);
    logic [32:0] limit;
    limit = {1'b0, base} + (33'(depth) << 2);
    return (pc[1:0] == 2'b00) && ({1'b0, pc} >= {1'b0, base}) && ({1'b0, pc} < limit);
  endfunction

endpackage

// File: rtl/fetch_q2.sv
// Two-entry FIFO of fetched {instr, pc}. Entry 0 is always the head, so the
// consumer sees it with no output register in the way.
module fetch_q2
  import mips_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_data,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t e0_q, e0_d;
  fetch_entry_t e1_q, e1_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) e0_d = push_data;
          else                 e1_d = push_data;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          e0_d    = e1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Count unchanged; the new word lands behind whatever survives the pop.
          if (count_q == 2'd1) begin
            e0_d = push_data;
          end else begin
            e0_d = e1_q;
            e1_d = push_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e0_q    <= '0;
      e1_q    <= '0;
      count_q <= 2'd0;
    end else begin
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      count_q <= count_d;
    end
  end

  assign head  = e0_q;
  assign count = count_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch controller: owns the fetch PC, drives a 1-cycle synchronous
// instruction ROM, buffers returns in fetch_q2 and handles redirect and fault.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
  parameter logic [31:0] IM_BASE  = mips_pkg::IM_BASE,
  parameter int          IM_DEPTH = mips_pkg::IM_DEPTH,
  parameter int          ADDR_W   = mips_pkg::IM_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  im_en,
  output logic [ADDR_W-1:0]     im_addr,
  input  logic [31:0]           im_rdata,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [31:0]           redirect_pc,
  output logic                  instr_valid,
  output logic [31:0]           instr,
  output logic [31:0]           instr_pc,
  output logic                  pc_fault,
  output mips_pkg::fetch_state_e dbg_state
);

  import mips_pkg::*;

  // Handshake: instr_valid/instr/instr_pc present the head word; it is consumed
  // on any edge where instr_valid & ~stall, and a redirect discards it instead.

  fetch_state_e state_q, state_d;
  logic [31:0]  fpc_q, fpc_d;
  logic [31:0]  tag_q, tag_d;
  logic         inflight_q, inflight_d;

  logic         fpc_ok;
  logic         pop;
  logic         issue;
  logic [2:0]   outstanding;
  logic [1:0]   q_count;
  fetch_entry_t q_head;
  fetch_entry_t q_push_data;

  assign fpc_ok      = pc_legal(fpc_q, IM_BASE, IM_DEPTH);
  assign instr_valid = (q_count != 2'd0);
  assign pop         = instr_valid & ~stall;
  assign outstanding = {1'b0, q_count} + {2'b00, inflight_q};

  // A pop this edge frees a slot, so a full pipe can still issue.
  assign issue = ~reset & (state_q == FS_RUN) & fpc_ok & ~redirect
               & ((outstanding < 3'd2) | pop);

  assign im_en   = issue;
  assign im_addr = ADDR_W'((fpc_q - IM_BASE) >> 2);

  assign q_push_data = '{instr: im_rdata, pc: tag_q};

  fetch_q2 u_q (
    .clk      (clk),
    .rst      (reset),
    .push     (inflight_q & ~redirect),
    .pop      (pop & ~redirect),
    .flush    (redirect),
    .push_data(q_push_data),
    .head     (q_head),
    .count    (q_count)
  );

  assign instr    = instr_valid ? q_head.instr : 32'd0;
  assign instr_pc = instr_valid ? q_head.pc    : 32'd0;
  assign pc_fault = (state_q == FS_FAULT);
  assign dbg_state = state_q;

  always_comb begin
    state_d    = state_q;
    fpc_d      = fpc_q;
    tag_d      = tag_q;
    inflight_d = 1'b0;
    if (redirect) begin
      state_d = FS_RUN;
      fpc_d   = redirect_pc;
    end else begin
      if (issue) begin
        inflight_d = 1'b1;
        tag_d      = fpc_q;
        fpc_d      = fpc_q + 32'd4;
      end
      // Fault only once every older legal word has left the pipe.
      if ((state_q == FS_RUN) && !fpc_ok && (q_count == 2'd0) && !inflight_q) begin
        state_d = FS_FAULT;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FS_RUN;
      fpc_q      <= RESET_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fpc_q      <= fpc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios plus random stall/redirect/reset,
// checked every cycle against a queue-based model of the fetch stream.
module tb_if_fetch_ctrl;
  import mips_pkg::*;

  localparam logic [31:0] BASE  = 32'h0000_3000;
  localparam logic [31:0] LIMIT = 32'h0000_7000;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         stall = 1'b0;
  logic         redirect = 1'b0;
  logic [31:0]  redirect_pc = 32'd0;
  logic [31:0]  im_rdata;
  logic         im_en;
  logic [11:0]  im_addr;
  logic         instr_valid;
  logic [31:0]  instr;
  logic [31:0]  instr_pc;
  logic         pc_fault;
  fetch_state_e dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  if_fetch_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .im_en      (im_en),
    .im_addr    (im_addr),
    .im_rdata   (im_rdata),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .pc_fault   (pc_fault),
    .dbg_state  (dbg_state)
  );

  function automatic bit legal(input logic [31:0] pc);
    return (pc[1:0] == 2'b00) && (pc >= BASE) && (pc < LIMIT);
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return 32'h1000_0000 + ((pc - BASE) >> 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic head(input logic [31:0] pc);
    chk("lit_valid", {31'd0, instr_valid}, 32'd1);
    chk("lit_pc", instr_pc, pc);
    chk("lit_instr", instr, 32'h1000_0000 + ((pc - 32'h3000) / 4));
  endtask

  // ROM: word i holds 0x1000_0000+i; junk on cycles without a read.
  initial begin
    logic        en_s;
    logic [11:0] a_s;
    im_rdata = 32'd0;
    forever begin
      @(negedge clk);
      en_s = im_en;
      a_s  = im_addr;
      @(posedge clk);
      #1;
      im_rdata = en_s ? (32'h1000_0000 + {20'd0, a_s}) : $urandom;
    end
  end

  // Model: delivered PCs in a queue, at most one PC in flight, next fetch PC, fault flag.
  logic [31:0] m_q[$];
  bit          m_fly;
  logic [31:0] m_fly_pc;
  logic [31:0] m_fpc;
  bit          m_fault;

  initial begin
    bit          e_valid, e_pop, e_en, to_fault;
    logic [31:0] e_pc, e_instr;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_q.delete();
        m_fly   = 0;
        m_fpc   = BASE;
        m_fault = 0;
        chk("rst_im_en", {31'd0, im_en}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", instr_pc, 32'd0);
        chk("rst_fault", {31'd0, pc_fault}, 32'd0);
        chk("rst_im_addr", {20'd0, im_addr}, 32'd0);
      end else begin
        e_valid = (m_q.size() > 0);
        e_pc    = e_valid ? m_q[0] : 32'd0;
        e_instr = e_valid ? word_at(m_q[0]) : 32'd0;
        e_pop   = e_valid && !stall;
        e_en    = !m_fault && legal(m_fpc) && !redirect && ((m_q.size() + m_fly < 2) || e_pop);
        chk("im_en", {31'd0, im_en}, {31'd0, e_en});
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, e_valid});
        chk("instr_pc", instr_pc, e_pc);
        chk("instr", instr, e_instr);
        chk("pc_fault", {31'd0, pc_fault}, {31'd0, m_fault});
        chk("dbg_state", {31'd0, dbg_state}, m_fault ? {31'd0, FS_FAULT} : {31'd0, FS_RUN});
        if (e_en) chk("im_addr", {20'd0, im_addr}, (m_fpc - BASE) >> 2);
        if (redirect) begin
          m_q.delete();
          m_fly   = 0;
          m_fpc   = redirect_pc;
          m_fault = 0;
        end else begin
          to_fault = !m_fault && !legal(m_fpc) && (m_q.size() == 0) && !m_fly;
          if (e_pop) void'(m_q.pop_front());
          if (m_fly) m_q.push_back(m_fly_pc);
          m_fly    = e_en;
          m_fly_pc = m_fpc;
          if (e_en) m_fpc = m_fpc + 32'd4;
          if (to_fault) m_fault = 1;
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    // Streaming from reset, then a 4-cycle stall at 0x3008.
    reset = 1'b0;
    #1;
    chk("c0_im_en", {31'd0, im_en}, 32'd1);
    chk("c0_im_addr", {20'd0, im_addr}, 32'd0);
    tick(); chk("c1_im_addr", {20'd0, im_addr}, 32'd1);
    chk("c1_valid", {31'd0, instr_valid}, 32'd0);
    tick(); head(32'h3000);
    tick(); head(32'h3004);
    tick(); stall = 1'b1; #1; head(32'h3008);
    chk("stall_im_en", {31'd0, im_en}, 32'd0);
    repeat (3) begin tick(); head(32'h3008); end
    tick(); stall = 1'b0; #1; head(32'h3008);
    tick(); head(32'h300C);
    tick(); head(32'h3010);
    // Redirect while streaming.
    tick(); redirect = 1'b1; redirect_pc = 32'h3040; #1;
    chk("redir_im_en", {31'd0, im_en}, 32'd0);
    tick(); redirect = 1'b0; #1;
    chk("redir_next_en", {31'd0, im_en}, 32'd1);
    chk("redir_next_addr", {20'd0, im_addr}, 32'h10);
    chk("redir_flushed", {31'd0, instr_valid}, 32'd0);
    tick(); chk("redir_bubble", {31'd0, instr_valid}, 32'd0);
    tick(); head(32'h3040);
    tick(); head(32'h3044);
    // Redirect together with stall.
    tick(); stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h3040;
    tick(); redirect = 1'b0; #1;
    chk("rs_flushed", {31'd0, instr_valid}, 32'd0);
    tick(); tick(); head(32'h3040);
    tick(); head(32'h3040);
    tick(); stall = 1'b0; #1; head(32'h3040);
    tick(); head(32'h3044);
    // Misaligned redirect -> fault, then recovery.
    tick(); redirect = 1'b1; redirect_pc = 32'h3002;
    tick(); redirect = 1'b0; #1;
    chk("mis_im_en", {31'd0, im_en}, 32'd0);
    tick(); chk("mis_fault", {31'd0, pc_fault}, 32'd1);
    chk("mis_valid", {31'd0, instr_valid}, 32'd0);
    tick(); redirect = 1'b1; redirect_pc = 32'h3000;
    tick(); redirect = 1'b0; #1;
    chk("rec_fault", {31'd0, pc_fault}, 32'd0);
    chk("rec_im_en", {31'd0, im_en}, 32'd1);
    tick(); tick(); head(32'h3000);
    // Last two ROM words, then fault past the end.
    tick(); redirect = 1'b1; redirect_pc = 32'h6FF8;
    tick(); redirect = 1'b0; #1;
    chk("end_addr0", {20'd0, im_addr}, 32'hFFE);
    tick(); chk("end_addr1", {20'd0, im_addr}, 32'hFFF);
    tick(); head(32'h6FF8);
    chk("end_no_issue", {31'd0, im_en}, 32'd0);
    tick(); head(32'h6FFC);
    tick(); chk("end_drained", {31'd0, instr_valid}, 32'd0);
    chk("end_not_yet", {31'd0, pc_fault}, 32'd0);
    tick(); chk("end_fault", {31'd0, pc_fault}, 32'd1);
    // Reset mid-stream.
    tick(); redirect = 1'b1; redirect_pc = 32'h3000;
    tick(); redirect = 1'b0;
    repeat (4) tick();
    reset = 1'b1; #1;
    chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("mid_rst_instr", instr, 32'd0);
    chk("mid_rst_pc", instr_pc, 32'd0);
    chk("mid_rst_en", {31'd0, im_en}, 32'd0);
    chk("mid_rst_addr", {20'd0, im_addr}, 32'd0);
    tick(); tick(); reset = 1'b0;
    tick(); tick(); head(32'h3000);
    // Random phase.
    for (int i = 0; i < 2500; i++) begin
      tick();
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 299) == 0) reset = 1'b1;
      stall    = ($urandom_range(0, 99) < 30);
      redirect = ($urandom_range(0, 99) < 6);
      case ($urandom_range(0, 9))
        0: redirect_pc = BASE + 32'($urandom_range(0, 4095)) * 4 + 32'($urandom_range(1, 3));
        1: redirect_pc = ($urandom_range(0, 1) == 0) ? 32'h2FFC : 32'h7000;
        2: redirect_pc = LIMIT - 32'($urandom_range(1, 4)) * 4;
        3: redirect_pc = $urandom;
        default: redirect_pc = BASE + 32'($urandom_range(0, 4095)) * 4;
      endcase
    end
    tick();
    reset = 1'b0; stall = 1'b0; redirect = 1'b0;
    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
